// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier in the reference clock domain.
// Holds the core in reset until the PLL lock has been stable, and records loss of lock and retries.
module pll_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked_in,
    input  logic       clear_status,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       lock_lost,
    output logic [7:0] retry_count,
    output logic [1:0] state
);

    localparam int unsigned MAX_A      = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                         PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int unsigned RETRY_W    = 8;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = '1;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_QUALIFY   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             sync_q;
    logic             lk_s;
    logic             retry_ev;
    logic             loss_ev;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
            lk_s   <= 1'b0;
        end else begin
            sync_q <= pll_locked_in;
            lk_s   <= sync_q;
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= ST_PLL_RST;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        retry_ev   = 1'b0;
        loss_ev    = 1'b0;
        case (cur_state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    next_state = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    next_state = ST_QUALIFY;
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state = ST_PLL_RST;
                    retry_ev   = 1'b1;
                end
            end
            ST_QUALIFY: begin
                if (!lk_s) begin
                    next_state = ST_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    next_state = ST_PLL_RST;
                    retry_ev   = 1'b1;
                    loss_ev    = 1'b1;
                end
            end
            default: next_state = ST_PLL_RST;
        endcase
    end

    // Shared dwell counter: restarts on every state entry, idles in RUN.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (next_state != cur_state) begin
            cnt <= '0;
        end else if (cur_state != ST_RUN) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Outputs decoded from the next state so they change on the transition edge.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            state        <= 2'd0;
        end else begin
            pll_rst      <= (next_state == ST_PLL_RST);
            core_reset_n <= (next_state == ST_RUN);
            state        <= 2'(next_state);
        end
    end

    // Sticky status; a simultaneous clear is applied before the event.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            lock_lost   <= 1'b0;
            retry_count <= '0;
        end else if (clear_status) begin
            lock_lost   <= loss_ev;
            retry_count <= retry_ev ? RETRY_W'(1) : '0;
        end else begin
            if (loss_ev) begin
                lock_lost <= 1'b1;
            end
            if (retry_ev && (retry_count != RETRY_MAX)) begin
                retry_count <= retry_count + RETRY_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_pll_lock_supervisor;

    logic       clk_74a = 1'b0;
    logic       reset_n;
    logic       pll_locked_in;
    logic       clear_status;
    logic       pll_rst;
    logic       core_reset_n;
    logic       lock_lost;
    logic [7:0] retry_count;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int n;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32)
    ) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .pll_locked_in(pll_locked_in),
        .clear_status (clear_status),
        .pll_rst      (pll_rst),
        .core_reset_n (core_reset_n),
        .lock_lost    (lock_lost),
        .retry_count  (retry_count),
        .state        (state)
    );

    always #5 clk_74a = ~clk_74a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_74a);
        #1;
    endtask

    // Samples spent with pll_rst high, starting from the current sample.
    task automatic measure_high(output int cnt);
        cnt = 0;
        while (pll_rst === 1'b1 && cnt < 1000) begin
            cnt++;
            tick();
        end
    endtask

    task automatic measure_low(output int cnt);
        cnt = 0;
        while (pll_rst === 1'b0 && cnt < 1000) begin
            cnt++;
            tick();
        end
    endtask

    task automatic measure_state(input logic [1:0] s, output int cnt);
        cnt = 0;
        while (state === s && cnt < 1000) begin
            cnt++;
            tick();
        end
    endtask

    task automatic wait_for_state(input string tag, input logic [1:0] s, input int budget);
        int k;
        k = 0;
        while (state !== s && k < budget) begin
            k++;
            tick();
        end
        check(tag, 32'(state), 32'(s));
    endtask

    // Drops lock just after an edge; the FSM reacts on the third edge.
    task automatic lose_lock(input string tag, input logic with_clear);
        pll_locked_in = 1'b0;
        tick();
        tick();
        check({tag, "_core_held"}, 32'(core_reset_n), 32'd1);
        if (with_clear) clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check({tag, "_core_low"}, 32'(core_reset_n), 32'd0);
        check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        check({tag, "_state"}, 32'(state), 32'd0);
    endtask

    task automatic relock(input string tag);
        pll_locked_in = 1'b1;
        measure_high(n);
        check({tag, "_pulse"}, 32'(n), 32'd4);
        wait_for_state({tag, "_run"}, 2'd3, 100);
        check({tag, "_core"}, 32'(core_reset_n), 32'd1);
    endtask

    initial begin
        reset_n       = 1'b0;
        pll_locked_in = 1'b1;
        clear_status  = 1'b0;
        repeat (3) tick();
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_core", 32'(core_reset_n), 32'd0);
        check("rst_retry", 32'(retry_count), 32'd0);
        check("rst_lost", 32'(lock_lost), 32'd0);
        check("rst_state", 32'(state), 32'd0);

        // Clean bring-up
        reset_n = 1'b1;
        measure_high(n);
        check("up_pulse", 32'(n), 32'd4);
        check("up_wait", 32'(state), 32'd1);
        tick();
        check("up_qual", 32'(state), 32'd2);
        check("up_core_qual", 32'(core_reset_n), 32'd0);
        measure_state(2'd2, n);
        check("up_qual_len", 32'(n), 32'd8);
        check("up_state", 32'(state), 32'd3);
        check("up_core", 32'(core_reset_n), 32'd1);
        check("up_retry", 32'(retry_count), 32'd0);
        check("up_lost", 32'(lock_lost), 32'd0);

        // Loss in RUN
        lose_lock("loss1", 1'b0);
        check("loss1_lost", 32'(lock_lost), 32'd1);
        check("loss1_retry", 32'(retry_count), 32'd1);
        relock("loss1");
        check("loss1_retry_kept", 32'(retry_count), 32'd1);

        // Status clear
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check("clr_lost", 32'(lock_lost), 32'd0);
        check("clr_retry", 32'(retry_count), 32'd0);

        // Clear coinciding with a loss event
        lose_lock("loss2", 1'b0);
        check("loss2_retry", 32'(retry_count), 32'd1);
        relock("loss2");
        lose_lock("loss3", 1'b1);
        check("loss3_lost", 32'(lock_lost), 32'd1);
        check("loss3_retry", 32'(retry_count), 32'd1);

        // Mid-sequence asynchronous reset during QUALIFY
        pll_locked_in = 1'b1;
        measure_high(n);
        check("mid_pulse_pre", 32'(n), 32'd4);
        wait_for_state("mid_qual", 2'd2, 50);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_pll_rst", 32'(pll_rst), 32'd1);
        check("mid_core", 32'(core_reset_n), 32'd0);
        check("mid_state", 32'(state), 32'd0);
        check("mid_retry", 32'(retry_count), 32'd0);
        check("mid_lost", 32'(lock_lost), 32'd0);
        tick();
        reset_n = 1'b1;
        relock("mid");

        // One-cycle glitch during QUALIFY
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_for_state("gl_qual", 2'd2, 50);
        repeat (4) tick();
        pll_locked_in = 1'b0;
        tick();
        pll_locked_in = 1'b1;
        tick();
        check("gl_still_qual", 32'(state), 32'd2);
        tick();
        check("gl_back_wait", 32'(state), 32'd1);
        tick();
        check("gl_requal", 32'(state), 32'd2);
        measure_state(2'd2, n);
        check("gl_qual_len", 32'(n), 32'd8);
        check("gl_run", 32'(state), 32'd3);
        check("gl_retry", 32'(retry_count), 32'd0);
        check("gl_lost", 32'(lock_lost), 32'd0);

        // Lock timeout with retry saturation
        reset_n       = 1'b0;
        pll_locked_in = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            measure_high(n);
            check($sformatf("to%0d_pulse", k), 32'(n), 32'd4);
            measure_low(n);
            check($sformatf("to%0d_wait", k), 32'(n), 32'd32);
            check($sformatf("to%0d_retry", k), 32'(retry_count), 32'(k));
        end
        for (int k = 4; k <= 255; k++) begin
            measure_high(n);
            measure_low(n);
        end
        check("to_sat_retry", 32'(retry_count), 32'd255);
        measure_high(n);
        check("to_sat_pulse", 32'(n), 32'd4);
        measure_low(n);
        check("to_nowrap_retry", 32'(retry_count), 32'd255);
        check("to_state", 32'(state), 32'd0);
        check("to_lost", 32'(lock_lost), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the core PLL from the 74.25 MHz reference domain. Drives the PLL's active-high reset, qualifies its `locked` output, and releases the core reset only after lock has been stable for a programmable time. Loss of lock or lock timeout re-enters the reset sequence and is recorded in sticky status. Sits between the PLL instance and the core reset tree.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (>=1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before core release (>=1).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK before retrying (>=1).
- `clk_74a`  in  1  reference clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pll_locked_in`  in  1  raw PLL `locked`, asynchronous to `clk_74a`.
- `clear_status`  in  1  single-cycle pulse; clears `lock_lost` and `retry_count`.
- `pll_rst`  out  1  active-high PLL reset.
- `core_reset_n`  out  1  active-low core reset; high only in RUN.
- `lock_lost`  out  1  sticky; set on loss of lock while in RUN.
- `retry_count`  out  8  number of re-entries to PLL_RST since reset/clear; saturates at 255.
- `state`  out  2  debug: 0 PLL_RST, 1 WAIT_LOCK, 2 QUALIFY, 3 RUN.

## Operation
- `pll_locked_in` passes through a 2-FF synchronizer (`lk_s`); all decisions use `lk_s`.
- One shared cycle counter, sized for the largest parameter, cleared on every state entry.
- PLL_RST: `pll_rst`=1. After PLL_RST_CYCLES cycles in state -> WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0. `lk_s`=1 -> QUALIFY. Counter reaches LOCK_TIMEOUT_CYCLES with `lk_s`=0 -> PLL_RST and retry_count+1.
- QUALIFY: `lk_s`=0 -> WAIT_LOCK (counter cleared, no retry increment, timeout restarts). `lk_s`=1 for LOCK_STABLE_CYCLES consecutive cycles -> RUN.
- RUN: `core_reset_n`=1. `lk_s`=0 -> PLL_RST, set `lock_lost`, retry_count+1.
- retry_count saturates at 255; it does not wrap.
- `clear_status` together with a set/increment event in the same cycle: the clear applies first, then the event. Result: `lock_lost`=1 if the event is loss of lock, and `retry_count`=1.
- `reset_n` low at any time, including mid-sequence: everything returns to its reset value immediately (asynchronous). The sequence restarts from PLL_RST.

## Timing
- Reset values: state=PLL_RST, `pll_rst`=1, `core_reset_n`=0, `lock_lost`=0, `retry_count`=0, synchronizer=0, counter=0.
- All outputs are registered and update on the same edge as the state transition.
- Input latency: a change on `pll_locked_in` before edge N is visible in `lk_s` after edge N+1. The state and output reaction occurs at edge N+2.
- Loss of lock to `core_reset_n` low: 2 edges after the edge where the change is sampled, plus 1 for the transition (same edge `pll_rst` rises).
- From `reset_n` release with `pll_locked_in` steady high:
  - PLL_RST_CYCLES cycles in PLL_RST.
  - ≥1 cycle in WAIT_LOCK (≥2 if the sync has not filled yet).
  - LOCK_STABLE_CYCLES cycles in QUALIFY.
  - Then `core_reset_n` rises.
- `pll_rst` pulse width is exactly PLL_RST_CYCLES cycles on every attempt.
- A 1-cycle glitch low on `lk_s` during QUALIFY restarts qualification. The same glitch in RUN forces a full reset.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
- Reset values: assert `reset_n`=0 -> `pll_rst`=1, `core_reset_n`=0, `retry_count`=0, `state`=0.
- Clean bring-up: release `reset_n` with `pll_locked_in`=1 -> `pll_rst` high exactly 4 cycles. `core_reset_n` rises after 8 QUALIFY cycles. `state`=3 and `retry_count`=0.
- Timeout: `pll_locked_in`=0 held -> every 36 cycles a new 4-cycle `pll_rst` pulse. `retry_count` increments 1,2,3…, saturates at 255 after 255 timeouts, and never wraps.
- Glitch in QUALIFY: drop `pll_locked_in` for 1 cycle after 5 QUALIFY cycles -> `state` returns to 1, then 8 fresh cycles are required. `retry_count` is unchanged and `lock_lost`=0.
- Loss in RUN: drop `pll_locked_in` -> `core_reset_n`=0 and `pll_rst`=1 at the 3rd edge. `lock_lost`=1, `retry_count`=1, and relock returns to RUN.
- Status clear: pulse `clear_status` -> `lock_lost`=0, `retry_count`=0. Pulse it in the same cycle as a RUN lock loss -> `lock_lost`=1, `retry_count`=1.
- Mid-sequence reset: assert `reset_n` during QUALIFY -> all outputs return to reset values immediately, and bring-up restarts with a 4-cycle `pll_rst`.
